// File: rtl/i2s_slave_receiver.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SDATA on clk and delivers left/right sample pairs.
// Optional macro I2S_RX_SYNC_EN adds two-flop input synchronisers ahead of the edge register.
module i2s_slave_receiver #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              BCLK,
    input  logic              LRCLK,
    input  logic              SDATA,
    output logic [DATA_W-1:0] leftAudio,
    output logic [DATA_W-1:0] rightAudio,
    output logic              frameValid,
    output logic              RightNLeft,
    output logic              shortSlot
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DW_C    = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    logic w_bclk;
    logic w_lr;
    logic w_sd;

`ifdef I2S_RX_SYNC_EN
    logic [1:0] r_bclk_sync;
    logic [1:0] r_lr_sync;
    logic [1:0] r_sd_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bclk_sync <= '0;
            r_lr_sync   <= '0;
            r_sd_sync   <= '0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], BCLK};
            r_lr_sync   <= {r_lr_sync[0], LRCLK};
            r_sd_sync   <= {r_sd_sync[0], SDATA};
        end
    end

    assign w_bclk = r_bclk_sync[1];
    assign w_lr   = r_lr_sync[1];
    assign w_sd   = r_sd_sync[1];
`else
    assign w_bclk = BCLK;
    assign w_lr   = LRCLK;
    assign w_sd   = SDATA;
`endif

    // Edge register: LRCLK and SDATA share the BCLK stage so they stay aligned with the edge.
    logic r_bclk_cur;
    logic r_bclk_prev;
    logic r_lr_cur;
    logic r_sd_cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bclk_cur  <= 1'b0;
            r_bclk_prev <= 1'b0;
            r_lr_cur    <= 1'b0;
            r_sd_cur    <= 1'b0;
        end else begin
            r_bclk_cur  <= w_bclk;
            r_bclk_prev <= r_bclk_cur;
            r_lr_cur    <= w_lr;
            r_sd_cur    <= w_sd;
        end
    end

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_lr_prev;
    logic              r_lr_vld;
    logic              r_have_left;
    logic              r_en_prev;

    logic              w_edge;
    logic              w_lr_chg;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_run_wr;
    logic [CNT_W-1:0]  w_run_pos;
    logic [CNT_W-1:0]  w_chg_pos;
    logic              w_chg_wr;
    logic              w_short;
    logic [DATA_W-1:0] w_bit_vec;
    logic [DATA_W-1:0] w_word;

    assign w_edge    = r_bclk_cur & ~r_bclk_prev;
    assign w_lr_chg  = r_lr_cur ^ r_lr_prev;
    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_bit_vec = {{(DATA_W-1){1'b0}}, r_sd_cur};

    // Bits at counts 1..DATA_W land MSB-first; count 0 is the I2S delay bit.
    assign w_run_wr  = (w_cnt_nxt != '0) && (w_cnt_nxt <= DW_C);
    assign w_run_pos = DW_C - w_cnt_nxt;

    // On the LRCLK change edge the sampled bit completes a slot that is still short of DATA_W.
    assign w_chg_wr  = (r_cnt < DW_C);
    assign w_chg_pos = DW_C - CNT_W'(1) - r_cnt;
    assign w_short   = (r_cnt < (DW_C - CNT_W'(1)));
    assign w_word    = w_chg_wr ? (r_shift | (w_bit_vec << w_chg_pos)) : r_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_lr_prev   <= 1'b0;
            r_lr_vld    <= 1'b0;
            r_have_left <= 1'b0;
            r_en_prev   <= 1'b0;
            leftAudio   <= '0;
            rightAudio  <= '0;
            frameValid  <= 1'b0;
            RightNLeft  <= 1'b0;
            shortSlot   <= 1'b0;
        end else begin
            frameValid <= 1'b0;
            r_en_prev  <= enable;
            if (enable && !r_en_prev) begin
                shortSlot <= 1'b0;
            end

            if (!enable) begin
                r_state     <= ST_IDLE;
                r_lr_vld    <= 1'b0;
                r_have_left <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state     <= ST_SYNC;
                        r_lr_vld    <= 1'b0;
                        r_have_left <= 1'b0;
                    end
                    // First edge only records LRCLK, so a slot already in progress is never used.
                    ST_SYNC: begin
                        if (w_edge) begin
                            r_lr_prev <= r_lr_cur;
                            r_lr_vld  <= 1'b1;
                            if (r_lr_vld && w_lr_chg) begin
                                r_cnt       <= '0;
                                r_shift     <= '0;
                                r_have_left <= 1'b0;
                                RightNLeft  <= r_lr_cur;
                                r_state     <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_edge) begin
                            r_lr_prev <= r_lr_cur;
                            if (w_lr_chg) begin
                                if (r_lr_prev) begin
                                    rightAudio  <= w_word;
                                    frameValid  <= r_have_left;
                                    r_have_left <= 1'b0;
                                end else begin
                                    leftAudio   <= w_word;
                                    r_have_left <= 1'b1;
                                end
                                if (w_short) begin
                                    shortSlot <= 1'b1;
                                end
                                r_shift    <= '0;
                                r_cnt      <= '0;
                                RightNLeft <= r_lr_cur;
                            end else begin
                                r_cnt <= w_cnt_nxt;
                                if (w_run_wr) begin
                                    r_shift <= r_shift | (w_bit_vec << w_run_pos);
                                end
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_slave_receiver.sv
// Directed self-checking bench for i2s_slave_receiver: drives standard I2S frames with a one-bit delay.
module tb_i2s_slave_receiver;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CNT_W  = 6;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              BCLK;
    logic              LRCLK;
    logic              SDATA;
    logic [DATA_W-1:0] leftAudio;
    logic [DATA_W-1:0] rightAudio;
    logic              frameValid;
    logic              RightNLeft;
    logic              shortSlot;

    int n_checks = 0;
    int n_errors = 0;
    int fv_cnt   = 0;
    int fv_base  = 0;
    logic [DATA_W-1:0] fv_left  = '0;
    logic [DATA_W-1:0] fv_right = '0;
    logic pend = 1'b0;

    i2s_slave_receiver #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .BCLK       (BCLK),
        .LRCLK      (LRCLK),
        .SDATA      (SDATA),
        .leftAudio  (leftAudio),
        .rightAudio (rightAudio),
        .frameValid (frameValid),
        .RightNLeft (RightNLeft),
        .shortSlot  (shortSlot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture the sample pair seen while the frame strobe is high.
    always @(negedge clk) begin
        if (rst && frameValid) begin
            fv_cnt   = fv_cnt + 1;
            fv_left  = leftAudio;
            fv_right = rightAudio;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One slot (or its first nper BCLK periods); period 0 carries the previous slot's trailing bit.
    task automatic send_slot(input logic lr, input logic [15:0] word, input int nbits,
                             input int slen, input int nper);
        logic b;
        for (int p = 0; p < nper; p++) begin
            if (p == 0)
                b = pend;
            else if (p - 1 < nbits)
                b = word[nbits - p];
            else
                b = 1'b0;
            BCLK  = 1'b0;
            LRCLK = lr;
            SDATA = b;
            repeat (4) @(negedge clk);
            BCLK = 1'b1;
            repeat (4) @(negedge clk);
        end
        if (nper == slen && slen - 1 < nbits)
            pend = word[nbits - slen];
        else
            pend = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        BCLK   = 1'b0;
        LRCLK  = 1'b0;
        SDATA  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_left",  32'(leftAudio),  32'h0);
        check("rst_right", 32'(rightAudio), 32'h0);
        check("rst_fv",    32'(frameValid), 32'h0);
        check("rst_rnl",   32'(RightNLeft), 32'h0);
        check("rst_short", 32'(shortSlot),  32'h0);

        rst    = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // 16-BCLK slots
        send_slot(1'b1, 16'h000, 12, 16, 16);
        send_slot(1'b0, 16'hA5C, 12, 16, 16);
        send_slot(1'b1, 16'h3F0, 12, 16, 16);
        fv_base = fv_cnt;
        send_slot(1'b0, 16'h801, 12, 12, 12);
        check("s16_fv_cnt", 32'(fv_cnt - fv_base), 32'd1);
        check("s16_left",   32'(fv_left),  32'hA5C);
        check("s16_right",  32'(fv_right), 32'h3F0);
        check("s16_short",  32'(shortSlot), 32'h0);
        check("s16_rnl",    32'(RightNLeft), 32'h0);

        // 12-BCLK slots: LSB arrives on the LRCLK change edge
        send_slot(1'b1, 16'h7FE, 12, 12, 12);
        fv_base = fv_cnt;
        send_slot(1'b0, 16'h0AB, 8, 8, 8);
        check("s12_fv_cnt", 32'(fv_cnt - fv_base), 32'd1);
        check("s12_left",   32'(fv_left),  32'h801);
        check("s12_right",  32'(fv_right), 32'h7FE);
        check("s12_short",  32'(shortSlot), 32'h0);

        // 8-BCLK slots are short
        send_slot(1'b1, 16'h0C3, 8, 8, 8);
        check("s8_left",  32'(leftAudio),  32'hAB0);
        check("s8_short", 32'(shortSlot),  32'h1);
        check("s8_rnl",   32'(RightNLeft), 32'h1);

        // Enable dropped mid-left-slot
        send_slot(1'b0, 16'h555, 12, 16, 6);
        check("s8_right", 32'(rightAudio), 32'hC30);
        enable  = 1'b0;
        fv_base = fv_cnt;
        send_slot(1'b1, 16'h111, 12, 16, 16);
        send_slot(1'b0, 16'h222, 12, 16, 16);
        check("dis_fv_cnt", 32'(fv_cnt - fv_base), 32'd0);
        check("dis_left",   32'(leftAudio),  32'hAB0);
        check("dis_right",  32'(rightAudio), 32'hC30);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("en_short_clr", 32'(shortSlot), 32'h0);
        send_slot(1'b1, 16'h0F0, 12, 16, 16);
        send_slot(1'b0, 16'h456, 12, 16, 16);
        send_slot(1'b1, 16'h9AB, 12, 16, 16);
        send_slot(1'b0, 16'h000, 12, 16, 16);
        check("resync_fv_cnt", 32'(fv_cnt - fv_base), 32'd1);
        check("resync_left",   32'(fv_left),  32'h456);
        check("resync_right",  32'(fv_right), 32'h9AB);

        // Reset pulsed mid-right-slot
        send_slot(1'b1, 16'hFFF, 12, 16, 5);
        rst = 1'b0;
        #1;
        check("mrst_left",  32'(leftAudio),  32'h0);
        check("mrst_right", 32'(rightAudio), 32'h0);
        check("mrst_rnl",   32'(RightNLeft), 32'h0);
        check("mrst_fv",    32'(frameValid), 32'h0);
        @(negedge clk);
        rst     = 1'b1;
        fv_base = fv_cnt;
        send_slot(1'b1, 16'hFFF, 12, 16, 16);
        send_slot(1'b0, 16'h135, 12, 16, 16);
        check("mrst_nofv",    32'(fv_cnt - fv_base), 32'd0);
        check("mrst_right_0", 32'(rightAudio), 32'h0);
        send_slot(1'b1, 16'hECA, 12, 16, 16);
        send_slot(1'b0, 16'h000, 12, 16, 16);
        check("mrst_fv_cnt", 32'(fv_cnt - fv_base), 32'd1);
        check("mrst_left2",  32'(fv_left),  32'h135);
        check("mrst_right2", 32'(fv_right), 32'hECA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
